// File: rtl/mips_instr_encoder.sv
// Packs symbolic MIPS instructions into 32-bit words and queues them with their byte addresses.
// Optional macro MIPS_DELAY_SLOT_EN appends a NOP delay-slot word after every BEQ, BNE and J.
module mips_instr_encoder #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic [ADDR_W-1:0] word_count,
    output logic              err_sticky,
    output logic              done
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
`ifdef MIPS_DELAY_SLOT_EN
    localparam int NEED = 2;
`else
    localparam int NEED = 1;
`endif
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    // Returns {legal, word}; illegal selects yield legal=0.
    function automatic logic [32:0] encode(input logic [3:0] f_op, input logic [4:0] f_rs,
                                           input logic [4:0] f_rt, input logic [4:0] f_rd,
                                           input logic [15:0] f_imm, input logic [25:0] f_tgt);
        logic [32:0] r;
        case (f_op)
            4'd0:    r = {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h20};
            4'd1:    r = {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h22};
            4'd2:    r = {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h24};
            4'd3:    r = {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h25};
            4'd4:    r = {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h2A};
            4'd5:    r = {1'b1, 6'h08, f_rs, f_rt, f_imm};
            4'd6:    r = {1'b1, 6'h0C, f_rs, f_rt, f_imm};
            4'd7:    r = {1'b1, 6'h23, f_rs, f_rt, f_imm};
            4'd8:    r = {1'b1, 6'h2B, f_rs, f_rt, f_imm};
            4'd9:    r = {1'b1, 6'h04, f_rs, f_rt, f_imm};
            4'd10:   r = {1'b1, 6'h05, f_rs, f_rt, f_imm};
            4'd11:   r = {1'b1, 6'h02, f_tgt};
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [1:0]        state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d, free_w;
    logic [ADDR_W-1:0] addr_q, addr_d, wcnt_q, wcnt_d;
    logic              err_q, err_d, done_q, done_d;
    logic [31:0]       last_word_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [31:0]       mem_word_q [DEPTH];
    logic [ADDR_W-1:0] mem_addr_q [DEPTH];

    logic [32:0] enc_w;
    logic        accept_w, push_w, slot_w, pop_w;
    logic [1:0]  n_push_w;

    assign enc_w    = encode(op_sel, rs, rt, rd, imm, target);
    assign accept_w = in_valid & in_ready;
    assign push_w   = accept_w & enc_w[32];
`ifdef MIPS_DELAY_SLOT_EN
    assign slot_w   = push_w & ((op_sel == 4'd9) | (op_sel == 4'd10) | (op_sel == 4'd11));
`else
    assign slot_w   = 1'b0;
`endif
    assign n_push_w = push_w ? (slot_w ? 2'd2 : 2'd1) : 2'd0;
    assign pop_w    = out_valid & out_ready;
    assign free_w   = CNT_W'(DEPTH) - count_q;
    assign count_d  = count_q + CNT_W'(n_push_w) - CNT_W'(pop_w);

    assign in_ready   = (state_q == ST_RUN) && (free_w >= CNT_W'(NEED));
    assign out_valid  = (count_q != '0);
    assign out_word   = out_valid ? mem_word_q[rd_ptr_q] : last_word_q;
    assign out_addr   = out_valid ? mem_addr_q[rd_ptr_q] : last_addr_q;
    assign word_count = wcnt_q;
    assign err_sticky = err_q;
    assign done       = done_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    addr_d  = BASE;
                    wcnt_d  = '0;
                    err_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (push_w) begin
                    addr_d = addr_q + (slot_w ? ADDR_W'(8) : ADDR_W'(4));
                    wcnt_d = wcnt_q + ADDR_W'(n_push_w);
                end
                if (accept_w && !enc_w[32]) err_d = 1'b1;
                if (accept_w && in_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (count_q == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            addr_q      <= BASE;
            wcnt_q      <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            last_word_q <= '0;
            last_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_q + PTR_W'(n_push_w);
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop_w);
            count_q  <= count_d;
            addr_q   <= addr_d;
            wcnt_q   <= wcnt_d;
            err_q    <= err_d;
            done_q   <= done_d;
            // Keep the last popped entry so the outputs hold once the FIFO empties.
            if (pop_w) begin
                last_word_q <= mem_word_q[rd_ptr_q];
                last_addr_q <= mem_addr_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_w) begin
            mem_word_q[wr_ptr_q] <= enc_w[31:0];
            mem_addr_q[wr_ptr_q] <= addr_q;
        end
        if (slot_w) begin
            mem_word_q[wr_ptr_q + PTR_W'(1)] <= '0;
            mem_addr_q[wr_ptr_q + PTR_W'(1)] <= addr_q + ADDR_W'(4);
        end
    end
endmodule
